// File: rtl/main_memory_pkg.sv
// Shared definitions for the main-memory responder and the cache blocks that talk to it.
package main_memory_pkg;

  localparam int unsigned WORD_WIDTH        = 32;
  localparam int unsigned WORDS_PER_BLOCK   = 4;
  localparam int unsigned BLOCK_OFFSET_BITS = 4;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StRespond,
    StRelease
  } mem_state_e;

  // Word offset 0 sits in the most significant slice of a block.
  function automatic logic [WORD_WIDTH-1:0] block_word(
    input logic [WORD_WIDTH*WORDS_PER_BLOCK-1:0] blk,
    input logic [1:0]                            offset
  );
    return blk[(WORDS_PER_BLOCK - 1 - int'(offset)) * WORD_WIDTH +: WORD_WIDTH];
  endfunction

endpackage

// File: rtl/main_memory_ctrl_timer.sv
// Loadable down-counter that times the memory access latency.
module mem_latency_timer #(
  parameter int unsigned LATENCY = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  logic dec_i,
  output logic zero_o
);

  localparam int unsigned CntWidth = $clog2(LATENCY) + 1;
  localparam logic [CntWidth-1:0] LoadVal = CntWidth'(LATENCY - 1);

  logic [CntWidth-1:0] cnt_q, cnt_d;

  // Load has priority; decrement stops at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = LoadVal;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CntWidth'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/main_memory_ctrl.sv
// Whole-block main-memory responder with fixed access latency and access statistics.
module main_memory_ctrl
  import main_memory_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned BLOCK_WIDTH = 128,
  parameter int unsigned LATENCY     = 4,
  parameter int unsigned COUNT_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   isLock,
  input  logic                   isMemRead,
  input  logic [ADDR_WIDTH-1:0]  address,
  input  logic [BLOCK_WIDTH-1:0] memWriteData,
  output logic [BLOCK_WIDTH-1:0] memReadData,
  output logic                   memReady,
  output logic                   busy,
  output logic [COUNT_WIDTH-1:0] readCount,
  output logic [COUNT_WIDTH-1:0] writeCount
);

  localparam int unsigned BlkIdxWidth = ADDR_WIDTH - BLOCK_OFFSET_BITS;
  localparam int unsigned NumBlocks   = 2 ** BlkIdxWidth;

  // Power-up content: every word holds its own word address.
  function automatic logic [BLOCK_WIDTH-1:0] init_block(input int unsigned b);
    logic [BLOCK_WIDTH-1:0] v;
    v = '0;
    for (int unsigned w = 0; w < WORDS_PER_BLOCK; w++) begin
      v[(WORDS_PER_BLOCK - 1 - w) * WORD_WIDTH +: WORD_WIDTH] =
          WORD_WIDTH'(b * WORDS_PER_BLOCK + w);
    end
    return v;
  endfunction

  mem_state_e             state_q, state_d;
  logic [BlkIdxWidth-1:0] blk_idx_q, blk_idx_d;
  logic                   is_read_q, is_read_d;
  logic [BLOCK_WIDTH-1:0] wdata_q, wdata_d;
  logic [BLOCK_WIDTH-1:0] rdata_q, rdata_d;
  logic                   ready_q, ready_d;
  logic [COUNT_WIDTH-1:0] rd_cnt_q, rd_cnt_d;
  logic [COUNT_WIDTH-1:0] wr_cnt_q, wr_cnt_d;
  logic                   timer_load, timer_dec, timer_zero;
  logic                   commit;
  logic                   unused_addr_offset;

  logic [BLOCK_WIDTH-1:0] mem_rd [NumBlocks];

  assign unused_addr_offset = ^address[BLOCK_OFFSET_BITS-1:0];

  mem_latency_timer #(
    .LATENCY(LATENCY)
  ) u_timer (
    .clk_i (clock),
    .rst_i (reset),
    .load_i(timer_load),
    .dec_i (timer_dec),
    .zero_o(timer_zero)
  );

  // Storage array; deliberately outside reset so contents survive it.
  for (genvar i = 0; i < NumBlocks; i++) begin : g_blk
    logic [BLOCK_WIDTH-1:0] blk_q = init_block(i);
    logic [BLOCK_WIDTH-1:0] blk_d;

    // Write the captured block on the commit edge of a write to this index.
    always_comb begin
      blk_d = blk_q;
      if (commit && !is_read_q && (blk_idx_q == BlkIdxWidth'(i))) begin
        blk_d = wdata_q;
      end
    end

    // Block storage register.
    always_ff @(posedge clock) begin
      blk_q <= blk_d;
    end

    assign mem_rd[i] = blk_q;
  end

  // Request FSM, commit and statistics next-state.
  always_comb begin
    state_d    = state_q;
    blk_idx_d  = blk_idx_q;
    is_read_d  = is_read_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    ready_d    = 1'b0;
    rd_cnt_d   = rd_cnt_q;
    wr_cnt_d   = wr_cnt_q;
    timer_load = 1'b0;
    timer_dec  = 1'b0;
    commit     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!isLock) begin
          blk_idx_d  = address[ADDR_WIDTH-1:BLOCK_OFFSET_BITS];
          is_read_d  = isMemRead;
          wdata_d    = memWriteData;
          timer_load = 1'b1;
          state_d    = StAccess;
        end
      end
      StAccess: begin
        if (timer_zero) begin
          commit  = 1'b1;
          ready_d = 1'b1;
          state_d = StRespond;
        end else begin
          timer_dec = 1'b1;
        end
      end
      StRespond: begin
        state_d = StRelease;
      end
      StRelease: begin
        // Requester must raise isLock before another access can start.
        if (isLock) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (commit) begin
      if (is_read_q) begin
        rdata_d = mem_rd[blk_idx_q];
        if (rd_cnt_q != '1) begin
          rd_cnt_d = rd_cnt_q + COUNT_WIDTH'(1);
        end
      end else if (wr_cnt_q != '1) begin
        wr_cnt_d = wr_cnt_q + COUNT_WIDTH'(1);
      end
    end
  end

  // Control, capture and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      blk_idx_q <= '0;
      is_read_q <= 1'b0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      ready_q   <= 1'b0;
      rd_cnt_q  <= '0;
      wr_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      blk_idx_q <= blk_idx_d;
      is_read_q <= is_read_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      ready_q   <= ready_d;
      rd_cnt_q  <= rd_cnt_d;
      wr_cnt_q  <= wr_cnt_d;
    end
  end

  assign memReadData = rdata_q;
  assign memReady    = ready_q;
  assign busy        = (state_q != StIdle);
  assign readCount   = rd_cnt_q;
  assign writeCount  = wr_cnt_q;

endmodule

// File: tb/tb_main_memory_ctrl.sv
// Randomized self-checking bench for main_memory_ctrl against a block-level memory model.
module tb_main_memory_ctrl;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  // Default configuration instance
  logic         reset0 = 1'b1, lock0 = 1'b1, rd0 = 1'b1;
  logic [9:0]   addr0 = '0;
  logic [127:0] wdata0 = '0, rdata0;
  logic         ready0, busy0;
  logic [15:0]  rc0, wc0;

  // Small-counter, single-cycle-latency instance
  logic         reset1 = 1'b1, lock1 = 1'b1, rd1 = 1'b1;
  logic [9:0]   addr1 = '0;
  logic [127:0] wdata1 = '0, rdata1;
  logic         ready1, busy1;
  logic [1:0]   rc1, wc1;

  main_memory_ctrl dut0 (
    .clock(clock), .reset(reset0), .isLock(lock0), .isMemRead(rd0), .address(addr0),
    .memWriteData(wdata0), .memReadData(rdata0), .memReady(ready0), .busy(busy0),
    .readCount(rc0), .writeCount(wc0)
  );

  main_memory_ctrl #(.LATENCY(1), .COUNT_WIDTH(2)) dut1 (
    .clock(clock), .reset(reset1), .isLock(lock1), .isMemRead(rd1), .address(addr1),
    .memWriteData(wdata1), .memReadData(rdata1), .memReady(ready1), .busy(busy1),
    .readCount(rc1), .writeCount(wc1)
  );

  int total = 0;
  int bad = 0;

  // Reference model of dut0
  logic [127:0] mdl_mem [64];
  logic [127:0] mdl_last_rd = '0;
  int           mdl_rd = 0;
  int           mdl_wr = 0;

  function automatic logic [127:0] init_blk(input int b);
    return {32'(4 * b), 32'(4 * b + 1), 32'(4 * b + 2), 32'(4 * b + 3)};
  endfunction

  function automatic logic [15:0] sat16(input int n);
    return (n > 65535) ? 16'hFFFF : 16'(n);
  endfunction

  // Issue one request on dut0; returns edges from capture to memReady seen high.
  // Inputs are scrambled while the access is in flight; isLock stays low on return.
  task automatic access0(input bit rd, input logic [9:0] a, input logic [127:0] d,
                         output int lat);
    @(negedge clock);
    lock0 = 1'b0; rd0 = rd; addr0 = a; wdata0 = d;
    @(posedge clock);
    lat = 0;
    while (lat < 50) begin
      @(posedge clock);
      lat++;
      @(negedge clock);
      if (ready0) break;
      addr0  = 10'($urandom);
      wdata0 = {$urandom, $urandom, $urandom, $urandom};
      rd0    = 1'($urandom);
    end
  endtask

  task automatic release0();
    lock0 = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset0 = 1'b1; reset1 = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    total++; if (rdata0 !== '0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", rdata0); end
    total++; if (ready0 !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", ready0); end
    total++; if (busy0 !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy0); end
    total++; if (rc0 !== '0) begin bad++; $display("FAIL reset_rc got=%0d exp=0", rc0); end
    total++; if (wc0 !== '0) begin bad++; $display("FAIL reset_wc got=%0d exp=0", wc0); end
    reset0 = 1'b0; reset1 = 1'b0;
  endtask

  task automatic test_read_block5();
    int lat;
    access0(1'b1, 10'h050, '0, lat);
    mdl_rd++; mdl_last_rd = mdl_mem[5];
    total++; if (lat != 4) begin bad++; $display("FAIL rd5_latency got=%0d exp=4", lat); end
    total++;
    if (rdata0 !== 128'h00000014_00000015_00000016_00000017) begin
      bad++; $display("FAIL rd5_data got=%h exp=00000014000000150000001600000017", rdata0);
    end
    total++; if (rc0 !== 16'd1) begin bad++; $display("FAIL rd5_rc got=%0d exp=1", rc0); end
    release0();
    total++; if (busy0 !== 1'b0) begin bad++; $display("FAIL rd5_idle busy=%b exp=0", busy0); end
  endtask

  task automatic test_write_read();
    int lat;
    logic [127:0] d = 128'hDEADBEEF_00000001_00000002_00000003;
    access0(1'b0, 10'h3F0, d, lat);
    mdl_wr++; mdl_mem[63] = d;
    total++; if (lat != 4) begin bad++; $display("FAIL wr_latency got=%0d exp=4", lat); end
    total++;
    if (rdata0 !== mdl_last_rd) begin
      bad++; $display("FAIL wr_rdata_hold got=%h exp=%h", rdata0, mdl_last_rd);
    end
    total++; if (wc0 !== sat16(mdl_wr)) begin bad++; $display("FAIL wr_wc got=%0d exp=%0d", wc0, mdl_wr); end
    release0();
    access0(1'b1, 10'h3F0, '0, lat);
    mdl_rd++; mdl_last_rd = mdl_mem[63];
    total++; if (rdata0 !== d) begin bad++; $display("FAIL wr_readback got=%h exp=%h", rdata0, d); end
    total++; if (rc0 !== sat16(mdl_rd)) begin bad++; $display("FAIL wr_rc got=%0d exp=%0d", rc0, mdl_rd); end
    release0();
  endtask

  task automatic test_hold_lock();
    int lat;
    int pulses = 0;
    int idle_cycles = 0;
    access0(1'b1, 10'h120, '0, lat);
    mdl_rd++; mdl_last_rd = mdl_mem[18];
    for (int i = 0; i < 20; i++) begin
      @(posedge clock);
      @(negedge clock);
      if (ready0) pulses++;
      if (!busy0) idle_cycles++;
    end
    total++; if (pulses != 0) begin bad++; $display("FAIL hold_extra_pulses got=%0d exp=0", pulses); end
    total++; if (idle_cycles != 0) begin bad++; $display("FAIL hold_busy_drop got=%0d exp=0", idle_cycles); end
    total++; if (rc0 !== sat16(mdl_rd)) begin bad++; $display("FAIL hold_rc got=%0d exp=%0d", rc0, mdl_rd); end
    release0();
    total++; if (busy0 !== 1'b0) begin bad++; $display("FAIL hold_release busy=%b exp=0", busy0); end
  endtask

  task automatic test_change_during_access();
    int lat;
    logic [127:0] d = {$urandom, $urandom, $urandom, $urandom};
    access0(1'b0, 10'h000, d, lat);
    mdl_wr++; mdl_mem[0] = d;
    release0();
    access0(1'b1, 10'h000, '0, lat);
    mdl_rd++; mdl_last_rd = mdl_mem[0];
    total++; if (rdata0 !== d) begin bad++; $display("FAIL chg_blk0 got=%h exp=%h", rdata0, d); end
    release0();
    access0(1'b1, 10'h010, '0, lat);
    mdl_rd++; mdl_last_rd = mdl_mem[1];
    total++;
    if (rdata0 !== mdl_mem[1]) begin
      bad++; $display("FAIL chg_blk1 got=%h exp=%h", rdata0, mdl_mem[1]);
    end
    release0();
  endtask

  task automatic test_reset_mid_write();
    int lat;
    @(negedge clock);
    lock0 = 1'b0; rd0 = 1'b0; addr0 = 10'h100; wdata0 = 128'hCAFEF00D_11111111_22222222_33333333;
    repeat (3) @(posedge clock);
    #1 reset0 = 1'b1;
    #1;
    total++; if (busy0 !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b exp=0", busy0); end
    total++; if (rdata0 !== '0) begin bad++; $display("FAIL rstmid_rdata got=%h exp=0", rdata0); end
    total++; if (rc0 !== '0 || wc0 !== '0) begin
      bad++; $display("FAIL rstmid_counts got=%0d/%0d exp=0/0", rc0, wc0);
    end
    lock0 = 1'b1;
    mdl_rd = 0; mdl_wr = 0; mdl_last_rd = '0;
    @(negedge clock);
    reset0 = 1'b0;
    access0(1'b1, 10'h100, '0, lat);
    mdl_rd++; mdl_last_rd = mdl_mem[16];
    total++;
    if (rdata0 !== 128'h00000040_00000041_00000042_00000043) begin
      bad++; $display("FAIL rstmid_readback got=%h exp=00000040000000410000004200000043", rdata0);
    end
    total++; if (rc0 !== 16'd1) begin bad++; $display("FAIL rstmid_rc got=%0d exp=1", rc0); end
    release0();
  endtask

  task automatic test_random();
    int lat;
    for (int n = 0; n < 40; n++) begin
      bit           rd = 1'($urandom);
      int           b  = int'($urandom_range(63, 0));
      logic [9:0]   a  = {6'(b), 4'($urandom)};
      logic [127:0] d  = {$urandom, $urandom, $urandom, $urandom};
      access0(rd, a, d, lat);
      if (rd) begin
        mdl_rd++; mdl_last_rd = mdl_mem[b];
      end else begin
        mdl_wr++; mdl_mem[b] = d;
      end
      total++; if (lat != 4) begin bad++; $display("FAIL rnd_latency n=%0d got=%0d exp=4", n, lat); end
      total++;
      if (rdata0 !== mdl_last_rd) begin
        bad++; $display("FAIL rnd_rdata n=%0d got=%h exp=%h", n, rdata0, mdl_last_rd);
      end
      total++;
      if (rc0 !== sat16(mdl_rd) || wc0 !== sat16(mdl_wr)) begin
        bad++; $display("FAIL rnd_counts n=%0d got=%0d/%0d exp=%0d/%0d", n, rc0, wc0, mdl_rd, mdl_wr);
      end
      release0();
      total++; if (busy0 !== 1'b0 || ready0 !== 1'b0) begin
        bad++; $display("FAIL rnd_idle n=%0d busy=%b ready=%b exp=0/0", n, busy0, ready0);
      end
    end
  endtask

  task automatic test_small_config();
    for (int n = 0; n < 5; n++) begin
      int lat;
      int b = int'($urandom_range(63, 0));
      logic [1:0] exp_rc = (n + 1 > 3) ? 2'd3 : 2'(n + 1);
      @(negedge clock);
      lock1 = 1'b0; rd1 = 1'b1; addr1 = {6'(b), 4'($urandom)};
      @(posedge clock);
      lat = 0;
      while (lat < 20) begin
        @(posedge clock);
        lat++;
        @(negedge clock);
        if (ready1) break;
      end
      total++; if (lat != 1) begin bad++; $display("FAIL small_latency n=%0d got=%0d exp=1", n, lat); end
      total++;
      if (rdata1 !== init_blk(b)) begin
        bad++; $display("FAIL small_data n=%0d got=%h exp=%h", n, rdata1, init_blk(b));
      end
      total++; if (rc1 !== exp_rc) begin bad++; $display("FAIL small_rc n=%0d got=%0d exp=%0d", n, rc1, exp_rc); end
      lock1 = 1'b1;
      repeat (2) @(posedge clock);
    end
    total++; if (wc1 !== 2'd0) begin bad++; $display("FAIL small_wc got=%0d exp=0", wc1); end
  endtask

  initial begin
    for (int b = 0; b < 64; b++) mdl_mem[b] = init_blk(b);
    test_reset();
    test_read_block5();
    test_write_read();
    test_hold_lock();
    test_change_during_access();
    test_reset_mid_write();
    test_random();
    test_small_config();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/main_memory_ctrl.md
Name: main_memory_ctrl

Overview:
- Clocked main-memory responder at the memory end of the cache/memory block interface (isMemRead, memWriteData, isLock, memReadData).
- Serves one whole-block (128-bit) read or write per request, with a fixed configurable access latency and a completion pulse.
- Replaces the untimed "#1 wait" with a real handshake, so cache controllers can be made synchronous against it.
- Also keeps saturating read/write access counters for hit/miss statistics benches.

Parameters:
- ADDR_WIDTH, 10, byte address width; block address = address[ADDR_WIDTH-1:4].
- BLOCK_WIDTH, 128, block width; four 32-bit words.
- LATENCY, 4, cycles from request capture to memReady; legal range >= 1.
- COUNT_WIDTH, 16, width of access statistics counters.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- isLock  in  1  active-low request; 0 = cache requests an access, held low until memReady.
- isMemRead  in  1  1 = block read, 0 = block write; sampled at capture.
- address  in  ADDR_WIDTH  byte address; bits [3:0] ignored.
- memWriteData  in  BLOCK_WIDTH  block to write; sampled at capture.
- memReadData  out  BLOCK_WIDTH  registered read block.
- memReady  out  1  one-cycle completion pulse.
- busy  out  1  1 in every state except IDLE.
- readCount  out  COUNT_WIDTH  completed reads, saturating.
- writeCount  out  COUNT_WIDTH  completed writes, saturating.

Behaviour:
- Storage: NUM_BLOCKS = 2**(ADDR_WIDTH-4) entries of BLOCK_WIDTH.
  - Word order within a block: word offset 0 at [127:96], offset 3 at [31:0].
  - Initial content (simulation init, not reset): each 32-bit word = its word address (byte address >> 2). Block b = {4b, 4b+1, 4b+2, 4b+3}.
  - Reset does not clear the array.
- Reset values: memReadData=0, memReady=0, busy=0, readCount=0, writeCount=0, state=IDLE, latency counter=0.
- FSM states: IDLE, ACCESS, RESPOND, RELEASE.
- IDLE:
  - If isLock==0 at an edge: capture block address, isMemRead and memWriteData; load counter with LATENCY-1; go to ACCESS.
  - Otherwise stay in IDLE.
- ACCESS:
  - If counter != 0: decrement and stay.
  - If counter == 0: commit the operation on this edge, set memReady=1, go to RESPOND.
    - Read: memReadData <= array[blk].
    - Write: array[blk] <= captured data.
  - Inputs are ignored during ACCESS; later changes to address or data have no effect.
- Timing: a request captured at edge E0 gives memReady high in the cycle after edge E0+LATENCY.
  - Example: LATENCY=4, isLock low before edge 0 → memReady high between edges 4 and 5.
- RESPOND: memReady returns to 0 on the next edge; go to RELEASE.
- RELEASE:
  - Wait until isLock==1, then go to IDLE.
  - If isLock is still 0, stay. A held-low isLock never starts a second access; the requester must raise isLock for at least one edge between requests.
- memReadData holds its value until the next read completes; writes do not change it.
- Counters:
  - Increment on the commit edge: readCount for reads, writeCount for writes.
  - Saturate at all-ones; no wrap.
- Reset mid-operation: return immediately to IDLE.
  - A write not yet committed is dropped and the array is unchanged.
  - A write already committed is kept.
- Address wrap: none needed; every block index is in range by construction.

Decomposition:
- Package main_memory_pkg:
  - state enum (IDLE, ACCESS, RESPOND, RELEASE);
  - WORD_WIDTH=32, WORDS_PER_BLOCK=4, BLOCK_OFFSET_BITS=4;
  - a function giving the word slice for a word offset, shared with the cache blocks.
- Sub-module mem_latency_timer: a loadable down-counter with a zero flag, sized $clog2(LATENCY)+1.
- The FSM, array and statistics counters live in main_memory_ctrl.

Test Plan:
- Reset, then read of address 10'h050 (block 5) with isLock low → memReady after 4 edges; memReadData = {32'h14, 32'h15, 32'h16, 32'h17}; readCount=1.
- Write of 128'hDEADBEEF_00000001_00000002_00000003 to address 10'h3F0, then read of the same address → read returns the written block; writeCount=1, readCount=1.
- Hold isLock low for 20 cycles after a read → exactly one memReady pulse; busy stays 1 in RELEASE until isLock rises.
- Change address and memWriteData during ACCESS of a write to 10'h000 → only the captured block 0 is modified; block 1 is unchanged.
- Assert reset 2 cycles into a write to 10'h100 → outputs return to reset values; a later read of 10'h100 returns the initial block {32'h40, 32'h41, 32'h42, 32'h43}.
- COUNT_WIDTH=2, five reads → readCount saturates at 3; LATENCY=1 variant: memReady in the cycle after the capture edge.
